// File: rtl/ysyx_23060191_ctrl.sv
// Multi-cycle sequencing controller for the NPC core: walks each instruction through
// fetch/decode/execute/memory/writeback, gates GPR/PC strobes, counts cycles and retires.
module ysyx_23060191_ctrl #(
  parameter int LSU_OPT_WIDTH = 4,
  parameter int CNT_WIDTH     = 64,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     ifu_req_valid,
  input  logic                     ifu_rsp_valid,
  output logic                     inst_we,
  input  logic                     dec_wr_en_rd,
  input  logic [LSU_OPT_WIDTH-1:0] dec_lsu_opt_code,
  input  logic                     dec_ebreak,
  output logic                     lsu_req_valid,
  input  logic                     lsu_rsp_valid,
  output logic                     gpr_we,
  output logic                     pc_we,
  output logic                     halt,
  output logic                     bus_err,
  output logic [CNT_WIDTH-1:0]     cycle_cnt,
  output logic [CNT_WIDTH-1:0]     instret_cnt,
  output logic [2:0]               state_o
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  logic [2:0]           state;
  logic [2:0]           next_state;
  logic [15:0]          wait_cnt;
  logic                 rsp_seen;
  logic                 waiting;
  logic                 timeout_hit;
  logic                 retire;
  logic                 bus_err_q;
  logic [CNT_WIDTH-1:0] cycle_q;
  logic [CNT_WIDTH-1:0] instret_q;

  // Each response is only meaningful in the state that waits for it.
  always_comb begin
    waiting  = 1'b0;
    rsp_seen = 1'b0;
    case (state)
      ST_FETCH: begin
        waiting  = 1'b1;
        rsp_seen = ifu_rsp_valid;
      end
      ST_MEM: begin
        waiting  = 1'b1;
        rsp_seen = lsu_rsp_valid;
      end
      default: begin
        waiting  = 1'b0;
        rsp_seen = 1'b0;
      end
    endcase
  end

  assign timeout_hit = waiting && !rsp_seen && (wait_cnt == TIMEOUT_LAST);
  assign retire      = (state == ST_WB) || ((state == ST_EXEC) && dec_ebreak);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection; a response arriving on the timeout cycle still wins.
  always_comb begin
    next_state = ST_FETCH;
    case (state)
      ST_FETCH: begin
        if (ifu_rsp_valid) begin
          next_state = ST_DECODE;
        end else if (timeout_hit) begin
          next_state = ST_HALT;
        end else begin
          next_state = ST_FETCH;
        end
      end
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC: begin
        if (dec_ebreak) begin
          next_state = ST_HALT;
        end else if (dec_lsu_opt_code != '0) begin
          next_state = ST_MEM;
        end else begin
          next_state = ST_WB;
        end
      end
      ST_MEM: begin
        if (lsu_rsp_valid) begin
          next_state = ST_WB;
        end else if (timeout_hit) begin
          next_state = ST_HALT;
        end else begin
          next_state = ST_MEM;
        end
      end
      ST_WB:   next_state = ST_FETCH;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_FETCH;
    endcase
  end

  // Output decode; requests depend on state only, strobes fire only in WB.
  always_comb begin
    ifu_req_valid = 1'b0;
    inst_we       = 1'b0;
    lsu_req_valid = 1'b0;
    gpr_we        = 1'b0;
    pc_we         = 1'b0;
    halt          = 1'b0;
    case (state)
      ST_FETCH: begin
        ifu_req_valid = 1'b1;
        inst_we       = ifu_rsp_valid;
      end
      ST_MEM: lsu_req_valid = 1'b1;
      ST_WB: begin
        gpr_we = dec_wr_en_rd;
        pc_we  = 1'b1;
      end
      ST_HALT: halt = 1'b1;
      default: begin
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
      end
    endcase
  end

  // Wait counter restarts on every state change, so entry into FETCH/MEM starts at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= 16'd0;
    end else if (next_state != state) begin
      wait_cnt <= 16'd0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt + 16'd1;
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Performance counters freeze once halted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else if (state != ST_HALT) begin
      cycle_q   <= cycle_q + CNT_WIDTH'(1);
      instret_q <= instret_q + (retire ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
    end else begin
      cycle_q   <= cycle_q;
      instret_q <= instret_q;
    end
  end

  // Sticky bus error flag, set only by a timeout-induced halt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= bus_err_q | timeout_hit;
    end
  end

  assign bus_err     = bus_err_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
  assign state_o     = state;

endmodule

// File: tb/tb_ysyx_23060191_ctrl.sv
// Directed self-checking bench for the NPC sequencing controller (TIMEOUT set to 8).
module tb_ysyx_23060191_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_rsp_valid, inst_we;
  logic        dec_wr_en_rd, dec_ebreak;
  logic [3:0]  dec_lsu_opt_code;
  logic        lsu_req_valid, lsu_rsp_valid;
  logic        gpr_we, pc_we, halt, bus_err;
  logic [63:0] cycle_cnt, instret_cnt;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;
  int gpr_pulses = 0;
  int wr_total = 0;
  int strobe_viol = 0;
  int total_cyc = 0;
  bit seen_fetch = 1'b1;

  always #5 clk = ~clk;

  ysyx_23060191_ctrl #(.LSU_OPT_WIDTH(4), .CNT_WIDTH(64), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_rsp_valid(ifu_rsp_valid), .inst_we(inst_we),
    .dec_wr_en_rd(dec_wr_en_rd), .dec_lsu_opt_code(dec_lsu_opt_code), .dec_ebreak(dec_ebreak),
    .lsu_req_valid(lsu_req_valid), .lsu_rsp_valid(lsu_rsp_valid),
    .gpr_we(gpr_we), .pc_we(pc_we), .halt(halt), .bus_err(bus_err),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // One random-mix cycle: drive responses, sample, track strobes, advance.
  task automatic cyc(input logic [2:0] es, input logic iv, input logic lv, inout bit ok);
    ifu_rsp_valid = iv;
    lsu_rsp_valid = lv;
    #1;
    if (state_o !== es) ok = 1'b0;
    if (gpr_we) gpr_pulses++;
    if ((gpr_we || pc_we) && state_o != 3'd4) strobe_viol++;
    if (pc_we) begin
      if (!seen_fetch) strobe_viol++;
      seen_fetch = 1'b0;
    end
    if (state_o == 3'd0) seen_fetch = 1'b1;
    tick();
    total_cyc++;
  endtask

  initial begin
    dec_wr_en_rd = 1'b0; dec_lsu_opt_code = 4'd0; dec_ebreak = 1'b0;
    rst_n = 1'b0; ifu_rsp_valid = 1'b0; lsu_rsp_valid = 1'b0;
    tick(); tick();
    #1;
    chk("rst_state", state_o, 3'd0);
    chk("rst_ifu_req", ifu_req_valid, 1'b1);
    chk("rst_halt", {halt, bus_err, lsu_req_valid, gpr_we, pc_we}, 5'd0);
    chk("rst_cycle", cycle_cnt, 64'd0);
    chk("rst_instret", instret_cnt, 64'd0);
    rst_n = 1'b1;

    // 1: addi, zero-wait fetch
    ifu_rsp_valid = 1'b1; dec_wr_en_rd = 1'b1; dec_lsu_opt_code = 4'd0;
    #1; chk("t1_inst_we", inst_we, 1'b1);
    tick(); ifu_rsp_valid = 1'b0; #1;
    chk("t1_decode", state_o, 3'd1);
    tick(); chk("t1_exec", {state_o, gpr_we, pc_we}, {3'd2, 2'b00});
    tick(); chk("t1_wb", {state_o, gpr_we, pc_we}, {3'd4, 2'b11});
    tick();
    chk("t1_fetch", state_o, 3'd0);
    chk("t1_instret", instret_cnt, 64'd1);
    chk("t1_cycle", cycle_cnt, 64'd4);

    // 2: store with 3 wait cycles in MEM
    ifu_rsp_valid = 1'b1; dec_wr_en_rd = 1'b0; dec_lsu_opt_code = 4'd8;
    tick(); ifu_rsp_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      lsu_rsp_valid = (i == 3);
      #1;
      chk("t2_mem", {state_o, lsu_req_valid, gpr_we, pc_we}, {3'd3, 3'b100});
      tick();
    end
    lsu_rsp_valid = 1'b0; #1;
    chk("t2_wb", {state_o, lsu_req_valid, gpr_we, pc_we}, {3'd4, 3'b001});
    tick();
    chk("t2_instret", instret_cnt, 64'd2);
    chk("t2_cycle", cycle_cnt, 64'd12);

    // 3a: fetch timeout
    for (int i = 0; i < 8; i++) begin
      #1; chk("t3_wait", {state_o, ifu_req_valid}, {3'd0, 1'b1});
      tick();
    end
    chk("t3_halt", {state_o, halt, bus_err, ifu_req_valid}, {3'd5, 3'b110});
    ifu_rsp_valid = 1'b1;
    tick(); tick();
    chk("t3_frozen", {cycle_cnt, instret_cnt}, {64'd20, 64'd2});
    chk("t3_absorb", state_o, 3'd5);

    // 3b: response on the timeout cycle wins
    do_reset();
    dec_ebreak = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ifu_rsp_valid = (i == 7);
      #1;
      if (i == 7) chk("t3b_inst_we", inst_we, 1'b1);
      tick();
    end
    ifu_rsp_valid = 1'b0;
    chk("t3b_decode", {state_o, bus_err}, {3'd1, 1'b0});

    // 4: ebreak
    tick(); chk("t4_exec", {state_o, pc_we, gpr_we}, {3'd2, 2'b00});
    tick();
    chk("t4_halt", {state_o, halt, bus_err}, {3'd5, 2'b10});
    chk("t4_counts", {cycle_cnt, instret_cnt}, {64'd10, 64'd1});
    for (int i = 0; i < 3; i++) begin
      ifu_rsp_valid = 1'b1; lsu_rsp_valid = 1'b1; #1;
      chk("t4_quiet", {state_o, ifu_req_valid, lsu_req_valid, inst_we, pc_we, gpr_we}, {3'd5, 5'd0});
      tick();
    end
    chk("t4_frozen", {cycle_cnt, instret_cnt}, {64'd10, 64'd1});

    // 5: reset while in MEM
    do_reset();
    dec_ebreak = 1'b0; dec_wr_en_rd = 1'b1; dec_lsu_opt_code = 4'd1;
    ifu_rsp_valid = 1'b1; tick(); ifu_rsp_valid = 1'b0; tick(); tick();
    chk("t5_mem", {state_o, lsu_req_valid}, {3'd3, 1'b1});
    do_reset();
    #1;
    chk("t5_fetch", {state_o, lsu_req_valid}, {3'd0, 1'b0});
    chk("t5_counts", {cycle_cnt, instret_cnt}, {64'd0, 64'd0});
    lsu_rsp_valid = 1'b1;
    tick(); tick();
    chk("t5_ignore", {state_o, lsu_req_valid, gpr_we, pc_we}, {3'd0, 3'b000});

    // 6: random instruction mix
    do_reset();
    total_cyc = 0;
    seen_fetch = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      int t, fl, ml;
      bit ok;
      t = $urandom_range(0, 2);
      fl = $urandom_range(0, 5);
      ml = $urandom_range(0, 5);
      ok = 1'b1;
      dec_wr_en_rd = (t != 2);
      dec_lsu_opt_code = (t == 0) ? 4'd0 : ((t == 1) ? 4'd1 : 4'd8);
      for (int j = 0; j <= fl; j++) cyc(3'd0, (j == fl), 1'($urandom_range(0, 1)), ok);
      cyc(3'd1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ok);
      cyc(3'd2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ok);
      if (t != 0) begin
        for (int j = 0; j <= ml; j++) cyc(3'd3, 1'($urandom_range(0, 1)), (j == ml), ok);
      end
      cyc(3'd4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ok);
      if (t != 2) wr_total++;
      if (!ok) chk("t6_seq", {32'd0, 32'(n)}, 64'hffff_ffff);
    end
    ifu_rsp_valid = 1'b0; lsu_rsp_valid = 1'b0;
    chk("t6_seq_done", state_o, 3'd0);
    chk("t6_instret", instret_cnt, 64'd1000);
    chk("t6_gpr_we", 64'(gpr_pulses), 64'(wr_total));
    chk("t6_strobes", 64'(strobe_viol), 64'd0);
    chk("t6_cycle", cycle_cnt, 64'(total_cyc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
